uart_rx_byte: RTL and testbench
===============================

# uart_rx_byte

Serial-to-byte receiver that sits directly upstream of the matrix-vector engine inside `tt_uart_mvm`. It samples the asynchronous UART line on `ui_in[3]` and recovers 8N1 frames using a mid-bit sampling counter. Each received byte goes into a single-entry holding register behind a valid/ready handshake. Framing errors and overruns are reported as one-cycle pulses, so the downstream command/loader stage sees only clean bytes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit, e.g. 10 MHz / 115200. Legal range is 4 to 65535.
- `SYNC_STAGES`, default 2: synchronizer depth on `rx_i`. Legal range is 2 to 3.

Ports:
- `clk`, input, 1: the single clock; all state is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `ena`, input, 1: design enable. While low, the FSM is forced to IDLE and no output pulses are produced. The holding register keeps its value.
- `rx_i`, input, 1: UART serial line, idle high, asynchronous to `clk`.
- `data_o`, output, 8: received byte, LSB received first.
- `valid_o`, output, 1: `data_o` holds an unconsumed byte.
- `ready_i`, input, 1: downstream accepts `data_o` on any cycle where `valid_o && ready_i`.
- `frame_err_o`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_o`, output, 1: one-cycle pulse when a completed byte is dropped.
- `busy_o`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Reset values:**
  - Synchronizer flops reset to 1.
  - FSM resets to IDLE.
  - `data_o` = 0x00.
  - `valid_o`, `frame_err_o`, `overrun_o` and `busy_o` all reset to 0.
- **Counters:** N = `CLKS_PER_BIT`, H = floor(N/2).
  - Bit counter is 3 bits.
  - Down-counter is ceil(log2(N)) bits.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** on synchronized rx = 0, go to START and load the counter with H−1.
- **START:** at counter = 0, sample the line.
  - Sample = 1: glitch. Return to IDLE with no output.
  - Sample = 0: load N−1 and go to DATA with bit index 0.
- **DATA:** at counter = 0, shift the sample into bit[index] (LSB first) and reload N−1.
  - After index 7, go to STOP.
- **STOP:** at counter = 0, sample the line.
  - Sample = 1: byte complete. Go to IDLE.
  - Sample = 0: pulse `frame_err_o`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until synchronized rx = 1, then go to IDLE. This covers break conditions, so a held-low line never produces bytes.
- **Holding register, on byte complete:**
  - If `valid_o` = 0, or `ready_i` = 1 in the same cycle: load `data_o` and set `valid_o` = 1.
  - Otherwise: keep the old byte and pulse `overrun_o`.
- **Consume:** `valid_o && ready_i` with no completion in that cycle clears `valid_o`. `data_o` is not cleared.
- **`ena` = 0 mid-frame:** the frame is abandoned silently, with no error pulse.

## Timing
- **Reference edge:** T0 is the edge at which IDLE first sees synchronized rx = 0. That is `SYNC_STAGES` edges after the first edge that samples `rx_i` low.
- **Sample points:**
  - Start bit: T0+H.
  - Data bit i: T0+H+(i+1)·N.
  - Stop bit: T0+H+9N.
- **Outputs at the stop sample:** `valid_o`, `data_o`, `frame_err_o` and `overrun_o` are registered at edge T0+H+9N and are visible during the following cycle.
- **Throughput:** IDLE is re-entered at T0+H+9N, so a start bit beginning immediately after the stop bit's midpoint is caught. Back-to-back frames at full line rate are supported.
- **Handshake:**
  - `ready_i` is sampled on the same edge that it qualifies.
  - There is no combinational path from `ready_i` to `valid_o`.
  - `data_o` is stable while `valid_o` = 1 and not consumed.
- **Asynchronous reset mid-frame:** all state returns to reset values immediately. A partial byte never appears.

## Structure
- **Package `tt_uart_pkg`:**
  - `rx_state_t` enum for the five states.
  - Default `CLKS_PER_BIT` constant, shared with the future TX block.
  - `UART_DATA_W` = 8.
- **Sub-module `sync_ff`:** parameterized N-flop synchronizer with reset value 1, reused for other asynchronous pins.
- **Top-level wiring:** `tt_uart_mvm` instantiates this block, with `rx_i` = `ui_in[3]` and `ready_i` driven by the MVM loader.

## Test plan
1. **Single byte:** N=8, send 0xA5 with `ready_i` = 1.
   - `data_o` = 0xA5 and `valid_o` is high for exactly one cycle at T0+4+72+1.
   - `frame_err_o` and `overrun_o` stay 0.
2. **Back-pressure / overrun:** N=8, `ready_i` = 0, send 0x3C then 0xC3 back-to-back.
   - `data_o` stays 0x3C with `valid_o` = 1.
   - `overrun_o` pulses once at the second stop sample.
   - Raising `ready_i` clears `valid_o`.
3. **Glitch rejection:** N=8, drive `rx_i` low for 3 cycles, then high.
   - FSM returns to IDLE from START.
   - `valid_o` and `frame_err_o` never assert.
4. **Framing error:** send 0x55 with the stop bit low, then hold low for 40 cycles.
   - `frame_err_o` pulses once and no `valid_o`.
   - `busy_o` stays high until the line returns high.
   - The next 0x81 frame is received correctly.
5. **Reset mid-frame:** pulse `rst_n` low during data bit 4 of 0xFF.
   - All outputs return to reset values immediately.
   - A following 0x12 frame is received as 0x12.
6. **Back-to-back stream:** N=87, send 0x00, 0xFF, 0x5A at full rate with `ready_i` = 1.
   - Three `valid_o` pulses exactly 10·87 cycles apart, carrying the correct bytes.

Source files
------------

// File: rtl/tt_uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit timing
// for the tt_uart_mvm RX/TX blocks.
package tt_uart_pkg;

    localparam int UART_DATA_W               = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 87;
    localparam int UART_SYNC_STAGES_DEFAULT  = 2;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Width of a down-counter that must hold CLKS_PER_BIT-1.
    function automatic int uart_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchronizer for asynchronous input pins; every stage resets to 1 so an
// idle-high line never looks active coming out of reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift chain: stage 0 captures the pin, the last stage feeds the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '1;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling, a single-entry valid/ready holding register,
// and one-cycle framing-error / overrun pulses.
module uart_rx_byte
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = UART_SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int               CNT_W       = uart_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       BIT_LAST    = 3'd7;

    logic                   rx_s;
    logic                   cnt_done_s;
    logic                   consume_s;
    logic                   can_load_s;

    rx_state_t              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             bit_idx_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   busy_q;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Bit-timer expiry and handshake conditions used by the FSM below.
    always_comb begin
        cnt_done_s = (cnt_q == {CNT_W{1'b0}});
        consume_s  = valid_q & ready_i;
        can_load_s = ~valid_q | ready_i;
    end

    // Receive FSM, bit timer, shift register and the holding register with its pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= {UART_DATA_W{1'b0}};
            data_q      <= {UART_DATA_W{1'b0}};
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (!ena) begin
                // Abandon any frame silently; the holding register is left untouched.
                state_q   <= RX_IDLE;
                busy_q    <= 1'b0;
                cnt_q     <= {CNT_W{1'b0}};
                bit_idx_q <= 3'd0;
            end else begin
                if (consume_s) begin
                    valid_q <= 1'b0;
                end
                case (state_q)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            state_q <= RX_START;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_HALF_M1;
                        end
                    end
                    RX_START: begin
                        if (!cnt_done_s) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (rx_s) begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= RX_DATA;
                            cnt_q     <= CNT_FULL_M1;
                            bit_idx_q <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        if (!cnt_done_s) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else begin
                            shift_q[bit_idx_q] <= rx_s;
                            cnt_q              <= CNT_FULL_M1;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (!cnt_done_s) begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end else if (rx_s) begin
                            // Byte complete: IDLE is re-entered here so a start bit
                            // right after the stop midpoint is still caught.
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                            if (can_load_s) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= RX_WAIT_IDLE;
                        end
                    end
                    RX_WAIT_IDLE: begin
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus random bytes on an N=8
// instance, and a full-rate stream on a default-timing (N=87) instance.
module tb_uart_rx_byte;

    localparam int N8   = 8;
    localparam int N87  = 87;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic       rx8, ready8, rx87, ready87;
    logic [7:0] data8, data87;
    logic       valid8, ferr8, ovr8, busy8;
    logic       valid87, ferr87, ovr87, busy87;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: accepted bytes with the cycle they were presented, plus pulse logs.
    int         acc8_cyc[$];
    logic [7:0] acc8_dat[$];
    int         acc87_cyc[$];
    logic [7:0] acc87_dat[$];
    int         ferr8_cyc[$];
    int         ovr8_cyc[$];
    int         valid8_cycles, busy8_cycles, busy8_last, ferr87_n, ovr87_n;
    logic       v8_prev = 1'b0, v87_prev = 1'b0;
    logic [7:0] d8_prev = 8'h00, d87_prev = 8'h00;

    uart_rx_byte #(.CLKS_PER_BIT(N8), .SYNC_STAGES(SYNC)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_i(rx8), .data_o(data8), .valid_o(valid8),
        .ready_i(ready8), .frame_err_o(ferr8), .overrun_o(ovr8), .busy_o(busy8)
    );

    uart_rx_byte #(.CLKS_PER_BIT(N87), .SYNC_STAGES(SYNC)) dut87 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_i(rx87), .data_o(data87), .valid_o(valid87),
        .ready_i(ready87), .frame_err_o(ferr87), .overrun_o(ovr87), .busy_o(busy87)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, 1 time unit after each rising edge. An accept happened at this edge if the
    // byte was valid in the previous cycle and ready was held across the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (v8_prev && ready8) begin
                acc8_cyc.push_back(cyc - 1);
                acc8_dat.push_back(d8_prev);
            end
            v8_prev = valid8;
            d8_prev = data8;
            if (valid8) valid8_cycles++;
            if (busy8) begin
                busy8_cycles++;
                busy8_last = cyc;
            end
            if (ferr8) ferr8_cyc.push_back(cyc);
            if (ovr8) ovr8_cyc.push_back(cyc);
            if (v87_prev && ready87) begin
                acc87_cyc.push_back(cyc - 1);
                acc87_dat.push_back(d87_prev);
            end
            v87_prev = valid87;
            d87_prev = data87;
            if (ferr87) ferr87_n++;
            if (ovr87) ovr87_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_logs();
        acc8_cyc.delete();
        acc8_dat.delete();
        acc87_cyc.delete();
        acc87_dat.delete();
        ferr8_cyc.delete();
        ovr8_cyc.delete();
        valid8_cycles = 0;
        busy8_cycles  = 0;
        busy8_last    = -1;
        ferr87_n      = 0;
        ovr87_n       = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx87 = v;
        else     rx8  = v;
    endtask

    // Drive one 8N1 frame starting at the current falling edge; t is that cycle number.
    task automatic send(input bit sel, input logic [7:0] b, input logic stop, output int t);
        int n;
        n = sel ? N87 : N8;
        t = cyc;
        drive(sel, 1'b0);
        tick(n);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]);
            tick(n);
        end
        drive(sel, stop);
        tick(n);
    endtask

    // Cycle (counted from the drive cycle) in which the completed byte becomes visible:
    // one edge to sample the pin, SYNC edges through the synchronizer, then H + 9N.
    function automatic int lat(input int n);
        return 1 + SYNC + n / 2 + 9 * n;
    endfunction

    initial begin
        int         t, t1, t2, r;
        int         t6[3];
        logic [7:0] exp6[3];
        logic [7:0] b;

        rst_n = 1'b0; ena = 1'b1; rx8 = 1'b1; rx87 = 1'b1; ready8 = 1'b1; ready87 = 1'b1;
        clear_logs();
        tick(3);
        chk("rst_data",  data8,   8'h00);
        chk("rst_valid", valid8,  1'b0);
        chk("rst_ferr",  ferr8,   1'b0);
        chk("rst_ovr",   ovr8,    1'b0);
        chk("rst_busy",  busy8,   1'b0);
        chk("rst_v87",   valid87, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Single byte 0xA5, then a few random bytes, all with ready held high.
        clear_logs();
        send(1'b0, 8'hA5, 1'b1, t);
        tick(16);
        chk("t1_acc_n", acc8_cyc.size(), 1);
        if (acc8_cyc.size() > 0) begin
            chk("t1_data", acc8_dat[0], 8'hA5);
            chk("t1_cyc",  acc8_cyc[0], t + lat(N8));
        end
        chk("t1_valid_cycles", valid8_cycles, 1);
        chk("t1_ferr_n", ferr8_cyc.size(), 0);
        chk("t1_ovr_n",  ovr8_cyc.size(), 0);
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            clear_logs();
            send(1'b0, b, 1'b1, t);
            tick(8);
            chk("t1r_acc_n", acc8_cyc.size(), 1);
            if (acc8_cyc.size() > 0) begin
                chk("t1r_data", acc8_dat[0], b);
                chk("t1r_cyc",  acc8_cyc[0], t + lat(N8));
            end
        end

        // Back-pressure: second back-to-back byte overruns, first byte is kept.
        clear_logs();
        ready8 = 1'b0;
        send(1'b0, 8'h3C, 1'b1, t1);
        send(1'b0, 8'hC3, 1'b1, t2);
        tick(16);
        chk("t2_valid", valid8, 1'b1);
        chk("t2_data",  data8, 8'h3C);
        chk("t2_ovr_n", ovr8_cyc.size(), 1);
        if (ovr8_cyc.size() > 0) chk("t2_ovr_cyc", ovr8_cyc[0], t2 + lat(N8));
        chk("t2_acc_before", acc8_cyc.size(), 0);
        ready8 = 1'b1;
        tick(2);
        chk("t2_valid_clr", valid8, 1'b0);
        chk("t2_data_kept", data8, 8'h3C);
        chk("t2_acc_n", acc8_cyc.size(), 1);
        if (acc8_dat.size() > 0) chk("t2_acc_data", acc8_dat[0], 8'h3C);

        // Glitch: 3-cycle low pulse is rejected after the half-bit check.
        clear_logs();
        rx8 = 1'b0;
        tick(3);
        rx8 = 1'b1;
        tick(20);
        chk("t3_busy_cycles", busy8_cycles, N8 / 2);
        chk("t3_valid_cycles", valid8_cycles, 0);
        chk("t3_ferr_n", ferr8_cyc.size(), 0);

        // Framing error with the line held low afterwards, then a clean 0x81.
        clear_logs();
        send(1'b0, 8'h55, 1'b0, t);
        tick(40);
        chk("t4_busy_held", busy8, 1'b1);
        r = cyc;
        rx8 = 1'b1;
        tick(10);
        chk("t4_ferr_n", ferr8_cyc.size(), 1);
        if (ferr8_cyc.size() > 0) chk("t4_ferr_cyc", ferr8_cyc[0], t + lat(N8));
        chk("t4_valid_cycles", valid8_cycles, 0);
        chk("t4_busy_last", busy8_last, r + SYNC);
        clear_logs();
        send(1'b0, 8'h81, 1'b1, t);
        tick(8);
        chk("t4_acc_n", acc8_cyc.size(), 1);
        if (acc8_cyc.size() > 0) begin
            chk("t4_data", acc8_dat[0], 8'h81);
            chk("t4_cyc",  acc8_cyc[0], t + lat(N8));
        end

        // Asynchronous reset during data bit 4 of 0xFF, with a byte pending.
        clear_logs();
        ready8 = 1'b0;
        b = 8'($urandom) | 8'h01;
        send(1'b0, b, 1'b1, t);
        tick(4);
        chk("t5_pend_valid", valid8, 1'b1);
        chk("t5_pend_data",  data8, b);
        rx8 = 1'b0;
        tick(N8);
        rx8 = 1'b1;
        tick(4 * N8 + 3);
        chk("t5_busy_pre", busy8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", valid8, 1'b0);
        chk("t5_rst_data",  data8, 8'h00);
        chk("t5_rst_busy",  busy8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5 * N8);
        clear_logs();
        ready8 = 1'b1;
        send(1'b0, 8'h12, 1'b1, t);
        tick(16);
        chk("t5_acc_n", acc8_cyc.size(), 1);
        if (acc8_cyc.size() > 0) begin
            chk("t5_data", acc8_dat[0], 8'h12);
            chk("t5_cyc",  acc8_cyc[0], t + lat(N8));
        end
        chk("t5_valid_cycles", valid8_cycles, 1);

        // Enable dropped mid-frame: frame abandoned with no byte and no error.
        clear_logs();
        b = 8'($urandom) & 8'hC3;
        rx8 = 1'b0;
        tick(N8);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) ena = 1'b0;
            if (i == 4) chk("t7_busy_off", busy8, 1'b0);
            rx8 = b[i];
            tick(N8);
        end
        rx8 = 1'b1;
        tick(N8);
        ena = 1'b1;
        tick(16);
        chk("t7_acc_n", acc8_cyc.size(), 0);
        chk("t7_valid_cycles", valid8_cycles, 0);
        chk("t7_ferr_n", ferr8_cyc.size(), 0);
        chk("t7_data_kept", data8, 8'h12);

        // Full-rate stream on the N=87 instance.
        clear_logs();
        exp6[0] = 8'h00;
        exp6[1] = 8'hFF;
        exp6[2] = 8'h5A;
        for (int i = 0; i < 3; i++) send(1'b1, exp6[i], 1'b1, t6[i]);
        tick(100);
        chk("t6_acc_n", acc87_cyc.size(), 3);
        if (acc87_cyc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t6_data", acc87_dat[i], exp6[i]);
                chk("t6_cyc",  acc87_cyc[i], t6[i] + lat(N87));
                if (i > 0) chk("t6_spacing", acc87_cyc[i] - acc87_cyc[i-1], 10 * N87);
            end
        end
        chk("t6_ferr_n", ferr87_n, 0);
        chk("t6_ovr_n",  ovr87_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
